// File: rtl/bram_tile_reader.sv
// rtl/bram_tile_reader.sv - strided BRAM Port B reader with credit-limited output FIFO
module bram_tile_reader #(
    parameter int DATA_W       = 256,
    parameter int ADDR_W       = 16,
    parameter int NUM_READS    = 384,
    parameter int ADDR_STRIDE  = 24,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_read,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              rd_en_b,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] bram_doutb,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              read_done,
    output logic [ADDR_W-1:0] current_addr
);
    localparam int CNT_W = $clog2(NUM_READS + 1);
    localparam int OUT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  NUM_C    = CNT_W'(NUM_READS);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_READS - 1);
    localparam logic [OUT_W-1:0]  DEPTH_C  = OUT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(ADDR_STRIDE);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        issue_cnt, beat_cnt;
    logic [OUT_W-1:0]        outstanding;
    logic [READ_LATENCY-1:0] vpipe;
    logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]       issue_addr;
    logic                    issue, push, pop, last_pop;

    assign out_valid  = (wr_ptr != rd_ptr);
    assign out_data   = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign pop        = out_valid && out_ready;
    assign push       = vpipe[READ_LATENCY-1];
    assign busy       = (state != IDLE);
    // The first read goes out on the start edge so rd_en_b is high in the very next cycle.
    assign issue_addr = (state == IDLE) ? base_addr : current_addr;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        last_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (start_read) begin
                    issue      = 1'b1;
                    state_next = (NUM_READS == 1) ? DRAIN : READ;
                end
            end
            READ: begin
                if (issue_cnt < NUM_C && outstanding < DEPTH_C) begin
                    issue = 1'b1;
                    if (issue_cnt == LAST_IDX) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && beat_cnt == LAST_IDX) begin
                    last_pop   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_en_b      <= 1'b0;
            rd_addr_b    <= '0;
            current_addr <= '0;
            issue_cnt    <= '0;
            beat_cnt     <= '0;
            outstanding  <= '0;
            vpipe        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            read_done    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            state     <= state_next;
            rd_en_b   <= issue;
            read_done <= last_pop;
            if (issue) begin
                rd_addr_b    <= issue_addr;
                current_addr <= issue_addr + STRIDE_C;
                issue_cnt    <= (state == IDLE) ? CNT_W'(1) : issue_cnt + 1'b1;
            end
            if (state == IDLE) beat_cnt <= '0;
            else if (pop)      beat_cnt <= beat_cnt + 1'b1;
            // Credits come back only on the edge after a pop, never combinationally.
            outstanding <= outstanding + OUT_W'(issue) - OUT_W'(pop);
            vpipe[0] <= rd_en_b;
            for (int i = 1; i < READ_LATENCY; i++) vpipe[i] <= vpipe[i-1];
            if (push) begin
                fifo_mem[wr_ptr[PTR_W-1:0]] <= bram_doutb;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: doc/bram_tile_reader.md
# bram_tile_reader

Read-side counterpart to the systolic-array write path. On a start pulse it walks a strided address sequence in the result BRAM (Port B) and issues one read per beat. It absorbs the fixed BRAM read latency in a small credit-controlled FIFO and streams the 256-bit words out on a valid/ready interface to the next pipeline stage (softmax/layer-norm/next GEMM loader). Full throughput is one word per clock when the consumer is always ready.

## Interface
- DATA_W, 256, BRAM word width
- ADDR_W, 16, BRAM address width
- NUM_READS, 384, words read per start
- ADDR_STRIDE, 24, address increment between consecutive reads
- READ_LATENCY, 1, cycles from rd_en_b sample edge to valid bram_doutb (1..3)
- FIFO_DEPTH, 4, output buffer depth (power of 2, ≥ READ_LATENCY+2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start_read  in  1  one-cycle pulse; begins a pass; ignored while busy
- base_addr  in  ADDR_W  first address, sampled with start_read
- rd_en_b  out  1  BRAM Port B read enable
- rd_addr_b  out  ADDR_W  BRAM Port B address
- bram_doutb  in  DATA_W  BRAM Port B read data
- out_data  out  DATA_W  streamed word (FIFO head)
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts beat when out_valid & out_ready
- busy  out  1  pass in progress
- read_done  out  1  one-cycle pulse, last beat accepted
- current_addr  out  ADDR_W  next address to be issued

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: on start_read go to READ. Load current_addr=base_addr, issue_cnt=0, beat_cnt=0, outstanding=0.
- READ: issue a read when issue_cnt<NUM_READS and outstanding<FIFO_DEPTH.
  - rd_en_b=1, rd_addr_b=current_addr.
  - current_addr += ADDR_STRIDE, mod 2^ADDR_W (wraps silently).
  - issue_cnt++.
  - After the last issue, go to DRAIN.
- outstanding = reads issued − beats popped (in flight + FIFO occupancy).
  - A pop in the same cycle does not free a credit until the next cycle.
  - outstanding never exceeds FIFO_DEPTH, so the FIFO can never overflow.
- Valid-return shift register, READ_LATENCY deep, tracks rd_en_b. On its tap, bram_doutb is pushed into the FIFO.
- FIFO output: out_valid = not empty. Pop on out_valid & out_ready. out_data is held stable while out_valid & !out_ready.
- DRAIN: when beat_cnt reaches NUM_READS−1 and a pop occurs:
  - read_done pulses for 1 cycle (registered, the cycle after the pop edge).
  - state returns to IDLE.
- busy=1 whenever state≠IDLE.
- start_read in READ/DRAIN is ignored: no counter or address change.
- start_read in the same cycle as the final pop is ignored. A new pass needs start_read while IDLE.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; rd_en_b=0, rd_addr_b=0, current_addr=0, out_valid=0, out_data=0, busy=0, read_done=0.
  - FIFO, counters and valid-return pipeline cleared.
- Reset mid-pass: abort. BRAM data returning after reset is discarded because the valid pipeline is cleared.
- Cycle numbering: start_read sampled at edge 0.
  - busy=1 and first rd_en_b=1 (addr=base_addr) at cycle 1.
  - Data is captured into the FIFO at edge 1+READ_LATENCY.
  - out_valid=1 from cycle 2+READ_LATENCY (cycle 3 at defaults).
- rd_en_b and rd_addr_b are registered outputs. rd_addr_b holds its last value when rd_en_b=0.
- out_ready constantly 1:
  - one rd_en_b per cycle for NUM_READS consecutive cycles;
  - one beat per cycle;
  - read_done at cycle NUM_READS+2+READ_LATENCY (387 at defaults).
- out_ready=0: issue stalls after exactly FIFO_DEPTH outstanding reads. Issue resumes the cycle after the first pop.
- Beat order equals issue order. Beat k carries mem[base_addr + k·ADDR_STRIDE mod 2^ADDR_W].

## Test plan
- Preload mem[k·24]=k+2 for k=0..383, then start_read with base_addr=0 and out_ready=1.
  - 384 beats, values 2..385 in order.
  - rd_en_b continuous from cycle 1.
  - read_done exactly once at cycle 387; busy low the next cycle.
- Same preload with out_ready toggled 1-0-0-1 pseudo-randomly.
  - Identical data sequence; no lost or duplicated beat.
  - outstanding never exceeds 4.
  - out_data stable during every stall cycle.
- out_ready=0 for 20 cycles after start.
  - Exactly 4 rd_en_b pulses (addrs 0, 24, 48, 72), then rd_en_b=0.
  - After release, the stream resumes at value 2.
- base_addr=65520, NUM_READS=4.
  - Addresses 65520, 8, 32, 56 (wrap mod 65536).
  - Data read from those locations.
- start_read pulsed again at cycle 100 mid-pass → ignored; still exactly 384 beats and one read_done.
- rst_n=0 for one cycle at cycle 50 while reads are in flight.
  - All outputs reset next cycle; no stale beat appears.
  - A subsequent start_read gives a clean full pass starting at value 2.
